// File: rtl/note_pkg.sv
// Shared definitions for the score player: score word layout, player states
// and the octave/semitone to linear note code encoder.
package note_pkg;

    localparam int END_BIT = 15;
    localparam int OCT_MSB = 14;
    localparam int OCT_LSB = 12;
    localparam int POS_MSB = 11;
    localparam int POS_LSB = 8;
    localparam int DUR_MSB = 7;
    localparam int DUR_LSB = 0;

    localparam int NOTES_PER_OCT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_e;

    // oct*12 as (oct<<3)+(oct<<2) keeps it to adders; 7*12+11 = 95 fits in 7 bits.
    function automatic logic [9:0] encode_note(input logic [2:0] oct, input logic [3:0] pos);
        logic [6:0] code;
        code = ({4'b0000, oct} << 3) + ({4'b0000, oct} << 2) + {3'b000, pos};
        return {3'b000, code};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle tempo ticks: counts 0..TICK_DIV-1 and pulses on
// the last count. Held at zero while clear is high.
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequence_encoder.sv
// Score player: walks an external synchronous score ROM and holds each entry's
// linear note code on the output for its duration in tempo ticks.
module note_sequence_encoder
    import note_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 50000,
    parameter int DUR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] score_addr,
    input  logic [15:0]       score_data,
    output logic [9:0]        note,
    output logic              gate,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        note_q, note_d;
    logic              gate_q, gate_d;
    logic              done_q, done_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;

    logic              tick;
    logic              entry_end;
    logic [2:0]        entry_oct;
    logic [3:0]        entry_pos;
    logic [DUR_W-1:0]  entry_dur;

    assign entry_end = score_data[END_BIT];
    assign entry_oct = score_data[OCT_MSB:OCT_LSB];
    assign entry_pos = score_data[POS_MSB:POS_LSB];
    assign entry_dur = DUR_W'(score_data[DUR_MSB:DUR_LSB]);

    // The prescaler only runs in PLAY, so every note starts on a fresh tick period.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state_q != PLAY),
        .tick  (tick)
    );

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        note_d    = note_q;
        gate_d    = gate_q;
        done_d    = 1'b0;
        dur_d     = dur_q;
        dur_cnt_d = dur_cnt_q;

        if (stop) begin
            state_d = IDLE;
            gate_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                        addr_d  = '0;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (entry_end) begin
                        if (loop_en) begin
                            addr_d  = '0;
                            state_d = FETCH;
                        end else begin
                            gate_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (entry_dur == '0) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end else begin
                        // A semitone of 12..15 is a rest: silence, keep the last pitch.
                        if (entry_pos < 4'(NOTES_PER_OCT)) begin
                            note_d = encode_note(entry_oct, entry_pos);
                            gate_d = 1'b1;
                        end else begin
                            gate_d = 1'b0;
                        end
                        dur_d     = entry_dur;
                        dur_cnt_d = '0;
                        state_d   = PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (dur_cnt_q == dur_q - DUR_W'(1)) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = FETCH;
                        end else begin
                            dur_cnt_d = dur_cnt_q + DUR_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            note_q    <= '0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            dur_q     <= '0;
            dur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            note_q    <= note_d;
            gate_q    <= gate_d;
            done_q    <= done_d;
            dur_q     <= dur_d;
            dur_cnt_q <= dur_cnt_d;
        end
    end

    assign score_addr = addr_q;
    assign note       = note_q;
    assign gate       = gate_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_note_sequence_encoder.sv
// Self-checking bench: a score-walking reference model predicts the per-cycle
// outputs, and scenario tasks add targeted checks for each behaviour.
module tb_note_sequence_encoder;

    localparam int TD    = 4;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [9:0]    note;
        logic          gate;
        logic          busy;
        logic          done;
        logic [AW-1:0] addr;
    } obs_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] score_addr;
    logic [15:0]   score_data;
    logic [9:0]    note;
    logic          gate;
    logic          busy;
    logic          done;

    logic [15:0]   rom [DEPTH];
    obs_t          exp_q[$];
    obs_t          act_q[$];
    logic [10:0]   comp_q[$];
    int            n_cmp;
    int            n_err;

    note_sequence_encoder #(
        .ADDR_W   (AW),
        .TICK_DIV (TD),
        .DUR_W    (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .score_addr (score_addr),
        .score_data (score_data),
        .note       (note),
        .gate       (gate),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous score ROM: one cycle of read latency.
    always @(posedge clk) score_data <= rom[score_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [15:0] mk(input logic e, input int oct, input int pos, input int dur);
        return {e, 3'(oct), 4'(pos), 8'(dur)};
    endfunction

    function automatic obs_t sample();
        return {note, gate, busy, done, score_addr};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'h8000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Walks the score entry by entry from address 0 (player freshly reset) and
    // lists the expected outputs for each cycle after start is taken, up to n.
    task automatic build_model(input int n, input logic lp);
        int          addr;
        logic [9:0]  nt;
        logic        gt;
        logic [15:0] w;
        addr = 0; nt = '0; gt = 1'b0;
        exp_q.delete();
        while (exp_q.size() < n) begin
            exp_q.push_back({nt, gt, 1'b1, 1'b0, AW'(addr)});
            exp_q.push_back({nt, gt, 1'b1, 1'b0, AW'(addr)});
            w = rom[addr];
            if (w[15]) begin
                if (lp) begin
                    addr = 0;
                end else begin
                    exp_q.push_back({nt, 1'b0, 1'b0, 1'b1, AW'(addr)});
                    exp_q.push_back({nt, 1'b0, 1'b0, 1'b0, AW'(addr)});
                    break;
                end
            end else if (w[7:0] == 8'd0) begin
                addr = (addr + 1) % DEPTH;
            end else begin
                if (int'(w[11:8]) < 12) begin
                    nt = 10'(int'(w[14:12]) * 12 + int'(w[11:8]));
                    gt = 1'b1;
                end else begin
                    gt = 1'b0;
                end
                repeat (int'(w[7:0]) * TD) exp_q.push_back({nt, gt, 1'b1, 1'b0, AW'(addr)});
                addr = (addr + 1) % DEPTH;
            end
        end
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endtask

    // Pulses start and compares every following cycle with the model.
    task automatic run_trace(input string name);
        obs_t a;
        obs_t e;
        act_q.delete();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            a = sample();
            e = exp_q[i];
            act_q.push_back(a);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: got note=%0d gate=%b busy=%b done=%b addr=%0d, expected note=%0d gate=%b busy=%b done=%b addr=%0d",
                         name, i, a.note, a.gate, a.busy, a.done, a.addr,
                         e.note, e.gate, e.busy, e.done, e.addr);
            end
        end
    endtask

    // Collapses the busy part of the trace (from the first LOAD result) into
    // distinct consecutive {note, gate} pairs.
    task automatic compress_busy();
        logic [10:0] p;
        comp_q.delete();
        for (int i = 2; i < act_q.size(); i++) begin
            if (act_q[i].busy !== 1'b1) break;
            p = {act_q[i].note, act_q[i].gate};
            if (comp_q.size() == 0 || comp_q[comp_q.size() - 1] !== p) comp_q.push_back(p);
        end
    endtask

    task automatic check_seq3(input string name, input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
        logic [10:0] want [3];
        want[0] = a; want[1] = b; want[2] = c;
        compress_busy();
        n_cmp++;
        if (comp_q.size() != 3) begin
            n_err++;
            $display("FAIL %s: got %0d note/gate segments, expected 3", name, comp_q.size());
        end
        for (int i = 0; i < 3 && i < comp_q.size(); i++) begin
            n_cmp++;
            if (comp_q[i] !== want[i]) begin
                n_err++;
                $display("FAIL %s segment %0d: got note=%0d gate=%b, expected note=%0d gate=%b",
                         name, i, comp_q[i][10:1], comp_q[i][0], want[i][10:1], want[i][0]);
            end
        end
    endtask

    task automatic check_idle_zero(input string name);
        obs_t a;
        a = sample();
        n_cmp++;
        if (a !== obs_t'(0)) begin
            n_err++;
            $display("FAIL %s: got note=%0d gate=%b busy=%b done=%b addr=%0d, expected all zero",
                     name, a.note, a.gate, a.busy, a.done, a.addr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_idle_zero("reset_state");
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        check_idle_zero("reset_beats_start");
        do_reset();
    endtask

    task automatic test_single_note();
        do_reset();
        clear_rom();
        rom[0] = mk(0, 3, 9, 2);
        build_model(1000, 1'b0);
        run_trace("single_note");
        n_cmp++;
        if (act_q[2].note !== 10'd45 || act_q[2].gate !== 1'b1) begin
            n_err++;
            $display("FAIL single_note_code: got note=%0d gate=%b, expected note=45 gate=1", act_q[2].note, act_q[2].gate);
        end
    endtask

    task automatic test_encode_sweep();
        do_reset();
        clear_rom();
        rom[0] = mk(0, 0, 0, $urandom_range(1, 3));
        rom[1] = mk(0, 7, 11, $urandom_range(1, 3));
        rom[2] = mk(0, 4, 5, $urandom_range(1, 3));
        build_model(1000, 1'b0);
        run_trace("encode_sweep");
        check_seq3("encode_sweep_seq", {10'd0, 1'b1}, {10'd95, 1'b1}, {10'd53, 1'b1});
    endtask

    task automatic test_rest_skip();
        do_reset();
        clear_rom();
        rom[0] = mk(0, 2, 4, 1);
        rom[1] = mk(0, 0, 12, 1);
        rom[2] = mk(0, 1, 1, 0);
        rom[3] = mk(0, 1, 2, 1);
        build_model(1000, 1'b0);
        run_trace("rest_skip");
        check_seq3("rest_skip_seq", {10'd28, 1'b1}, {10'd28, 1'b0}, {10'd14, 1'b1});
    endtask

    task automatic test_loop();
        int  n_done;
        int  n_bad_addr;
        bit  seen;
        do_reset();
        clear_rom();
        rom[0] = mk(0, 5, 0, 1);
        loop_en = 1'b1;
        build_model(40, 1'b1);
        run_trace("loop");
        n_done = 0; n_bad_addr = 0;
        foreach (act_q[i]) begin
            if (act_q[i].done === 1'b1) n_done++;
            if (act_q[i].addr > 1) n_bad_addr++;
        end
        n_cmp++;
        if (n_done != 0 || n_bad_addr != 0) begin
            n_err++;
            $display("FAIL loop_no_done: got %0d done pulses and %0d addresses outside 0..1, expected 0 and 0", n_done, n_bad_addr);
        end
        @(negedge clk);
        loop_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL loop_exit_done: got no done within 60 cycles, expected one");
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || note !== 10'd60) begin
            n_err++;
            $display("FAIL loop_exit_idle: got busy=%b done=%b note=%0d, expected busy=0 done=0 note=60", busy, done, note);
        end
    endtask

    task automatic test_addr_wrap();
        bit wrapped;
        do_reset();
        for (int i = 0; i < DEPTH; i++) rom[i] = mk(0, $urandom_range(0, 7), $urandom_range(0, 11), 1);
        build_model(DEPTH * (2 + TD) + 20, 1'b0);
        run_trace("addr_wrap");
        wrapped = 1'b0;
        for (int i = 1; i < act_q.size(); i++) begin
            if (act_q[i - 1].addr == AW'(DEPTH - 1) && act_q[i].addr == '0 && act_q[i].busy === 1'b1) wrapped = 1'b1;
        end
        n_cmp++;
        if (!wrapped) begin
            n_err++;
            $display("FAIL addr_wrap_seen: got no busy step from address %0d to 0, expected one", DEPTH - 1);
        end
    endtask

    task automatic test_stop();
        int n_bad;
        do_reset();
        clear_rom();
        rom[0] = mk(0, 2, 7, 3);
        build_model(6, 1'b0);
        run_trace("stop_pre");
        stop = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || gate !== 1'b0 || done !== 1'b0 || note !== 10'd31) begin
            n_err++;
            $display("FAIL stop_play: got busy=%b gate=%b done=%b note=%0d, expected busy=0 gate=0 done=0 note=31", busy, gate, done, note);
        end
        stop = 1'b0; start = 1'b0;
        n_bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) n_bad++;
        end
        stop = 1'b1; start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) n_bad++;
        end
        stop = 1'b0; start = 1'b0;
        n_cmp++;
        if (n_bad != 0) begin
            n_err++;
            $display("FAIL stop_stays_idle: got %0d active cycles, expected 0", n_bad);
        end
        do_reset();
        clear_rom();
        build_model(2, 1'b0);
        run_trace("stop_load_pre");
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        n_bad = (busy !== 1'b0 || done !== 1'b0) ? 1 : 0;
        @(posedge clk);
        #1;
        if (busy !== 1'b0 || done !== 1'b0) n_bad++;
        n_cmp++;
        if (n_bad != 0) begin
            n_err++;
            $display("FAIL stop_over_end: got %0d cycles with busy or done set, expected 0", n_bad);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_rom();
        rom[0] = mk(0, 1, 0, 1);
        rom[1] = mk(0, 6, 3, 3);
        build_model(10, 1'b0);
        run_trace("reset_mid_pre");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_zero("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        build_model(1000, 1'b0);
        run_trace("reset_mid_replay");
    endtask

    task automatic test_random();
        logic lp;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) begin
                rom[i] = mk($urandom_range(0, 5) == 0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3));
            end
            lp = 1'($urandom_range(0, 1));
            loop_en = lp;
            build_model(250, lp);
            run_trace($sformatf("random_%0d", it));
        end
        do_reset();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        clear_rom();
        test_reset();
        test_single_note();
        test_encode_sweep();
        test_rest_skip();
        test_loop();
        test_addr_wrap();
        test_stop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
